seq_gen_tx: RTL
===============

Name: seq_gen_tx

Overview:
- Serial pattern transmitter: the sending end of the team's serial sequence-detector link.
- On a start strobe it captures a WIDTH-bit pattern and a repeat count.
- It shifts the pattern MSB-first onto a 1-bit line `x`, repeat_n times, with optional idle gap cycles between repetitions.
- It flags completion with a one-cycle done pulse. Its `x` output drives the detector's serial input directly (same clock domain).

Parameters:
- WIDTH, 4, pattern length in bits (>=2).
- CNT_W, 4, width of the repeat_n port.
- GAP, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back, no gap after last repetition).
- IDLE_BIT, 0, level driven on `x` when not shifting.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled on posedge, honoured only when idle.
- pattern  input  WIDTH  bit pattern to send; bit WIDTH-1 is sent first.
- repeat_n  input  CNT_W  number of transmissions; 0 is treated as 1.
- x  output  1  serial data out, registered.
- x_valid  output  1  high while `x` carries a pattern bit, registered.
- busy  output  1  high from the cycle after start acceptance through the last bit.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (asynchronous, no clock needed):
  - state=IDLE, x=IDLE_BIT, x_valid=0, busy=0, done=0.
  - Shift register, saved pattern, bit counter, repeat counter and gap counter all cleared.
- States:
  - IDLE: x=IDLE_BIT, x_valid=0, busy=0.
    - start=1 at posedge: capture pattern into both the shift register and the saved-pattern register; capture max(repeat_n,1) into the repeat counter; go to SHIFT.
  - SHIFT: x=shreg[WIDTH-1], x_valid=1, busy=1. Each posedge shifts left one bit and increments the bit counter.
    - After WIDTH bits with remaining repeats >1: decrement the repeat counter and reload the shift register from the saved pattern.
      - If GAP>0, go to GAP.
      - If GAP=0, stay in SHIFT; the first bit of the next repetition follows the last bit with no bubble.
    - After WIDTH bits on the last repeat: go to IDLE and assert done.
  - GAP: x=IDLE_BIT, x_valid=0, busy=1 for exactly GAP cycles, then return to SHIFT.
- Latency and timing:
  - Start sampled at edge N: first bit is on `x` from edge N to N+1, with busy=1 and x_valid=1 in that cycle.
  - Total busy cycles = WIDTH*R + GAP*(R-1), where R = max(repeat_n,1).
  - done=1 for exactly the one cycle after the last bit; busy=0 in that cycle.
- Start rules:
  - start while busy is ignored. The captured pattern and count are unaffected by later changes to the pattern or repeat_n inputs.
  - start during the done cycle is accepted (state is IDLE). The minimum spacing between transmissions is therefore one idle cycle.
- Registered outputs: all outputs come from registers, with no combinational path from inputs to outputs.
- Counters:
  - Bit counter is sized clog2(WIDTH)+1 and wraps to 0 on each reload.
  - Repeat counter is CNT_W bits and never underflows; the exit condition is checked at value 1.
- Reset mid-operation: takes effect immediately. The transmission is aborted, no done pulse is produced, and the next start is accepted normally.

Test Plan:
1. WIDTH=4, GAP=0. Reset, then start with pattern=4'b1011, repeat_n=1.
   -> x = 1,0,1,1 over the next 4 cycles with x_valid=1 and busy=1 in all four; done=1 in cycle 5; x=0, busy=0 afterwards.
2. GAP=1, pattern=4'b1011, repeat_n=3.
   -> x sequence 1011 _ 1011 _ 1011 with x_valid=0 in the two gap cycles; busy high for 14 cycles; exactly one done pulse.
3. repeat_n=0, pattern=4'b0110.
   -> single transmission 0,1,1,0; busy for 4 cycles; done once.
4. Start pattern=4'b1011, then on cycle 2 pulse start with pattern=4'b0000, repeat_n=5.
   -> first transmission completes unchanged as 1011; second start ignored; only one done pulse. Then start on the done cycle -> accepted, and its first bit appears on the next cycle.
5. Assert reset asynchronously (between clock edges) during the 3rd bit of a transmission.
   -> x=0, x_valid=0, busy=0 immediately, before the next edge; no done pulse. A following start transmits normally.
6. Loopback into the detector: GAP=0, repeat_n=2, pattern=4'b1011.
   -> x stream 10111011; the detector's detect output asserts twice, once after each 4-bit group.

Source files
------------

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern MSB-first onto x, R times.
// Latency: first bit on x in the cycle after start is sampled; done pulses the cycle after the last bit.
// Backpressure: none; start is ignored while a transmission is in progress.
module seq_gen_tx #(
    parameter int WIDTH    = 4,
    parameter int CNT_W    = 4,
    parameter int GAP      = 0,
    parameter bit IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   saved_q;
    logic [BW-1:0]      bit_q;
    logic [CNT_W-1:0]   rep_q;
    logic [GW-1:0]      gap_q;
    logic               x_q;
    logic               x_valid_q;
    logic               busy_q;
    logic               done_q;

    logic [CNT_W-1:0]   rep_init_d;
    logic               last_bit_d;
    logic               last_gap_d;

    // A repeat count of zero still sends the pattern once.
    always_comb begin
        rep_init_d = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
        last_bit_d = (bit_q == BW'(WIDTH - 1));
        last_gap_d = (gap_q == GW'(GAP - 1));
    end

    // Transmit FSM; every output is a flop so x can feed the detector directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            saved_q   <= '0;
            bit_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shreg_q   <= pattern;
                        saved_q   <= pattern;
                        rep_q     <= rep_init_d;
                        bit_q     <= '0;
                        gap_q     <= '0;
                        x_q       <= pattern[WIDTH-1];
                        x_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (last_bit_d) begin
                        bit_q <= '0;
                        if (rep_q > CNT_W'(1)) begin
                            // More repetitions to go: reload from the saved copy.
                            rep_q   <= rep_q - CNT_W'(1);
                            shreg_q <= saved_q;
                            if (GAP > 0) begin
                                gap_q     <= '0;
                                x_q       <= IDLE_BIT;
                                x_valid_q <= 1'b0;
                                state_q   <= S_GAP;
                            end else begin
                                x_q <= saved_q[WIDTH-1];
                            end
                        end else begin
                            x_q       <= IDLE_BIT;
                            x_valid_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end else begin
                        shreg_q <= shreg_q << 1;
                        x_q     <= shreg_q[WIDTH-2];
                        bit_q   <= bit_q + BW'(1);
                    end
                end
                S_GAP: begin
                    if (last_gap_d) begin
                        gap_q     <= '0;
                        x_q       <= saved_q[WIDTH-1];
                        x_valid_q <= 1'b1;
                        state_q   <= S_SHIFT;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
